// File: rtl/rv_pkg.sv
// Shared constants and types for the rv_periph_ctrl peripheral slice.
// Holds the address map, register offsets and the seven-segment type.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] ADDRESS_PER = 32'h8000_0000;
    localparam logic [XLEN-1:0] ADDRESS_HEX = ADDRESS_PER + 32'h4;
    localparam logic [XLEN-1:0] ADDRESS_KEY = ADDRESS_PER + 32'h8;

    localparam logic [3:0] PER_CTRL_OFF = 4'h0;
    localparam logic [3:0] PER_HEX_OFF  = 4'h4;
    localparam logic [3:0] PER_KEY_OFF  = 4'h8;
    localparam logic [3:0] PER_EDGE_OFF = 4'hC;

    localparam int PER_CTRL_IRQ_BIT = 16;

    // Active-low segments, bit 0 = a ... bit 6 = g.
    typedef logic [6:0] seg7_t;
    localparam seg7_t SEG7_BLANK = 7'h7F;

    function automatic logic [XLEN-1:0] be_to_mask(input logic [3:0] be);
        logic [XLEN-1:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rv_hex7seg.sv
// Combinational nibble-to-segment decoder, active-low outputs (0-F).
module rv_hex7seg
    import rv_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    always_comb begin
        seg_o = SEG7_BLANK;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = SEG7_BLANK;
        endcase
    end

endmodule

// File: rtl/rv_periph_ctrl.sv
// Memory-mapped seven-segment / key peripheral with edge interrupt.
// Define RV_PERIPH_DEBOUNCE_EN to add per-key debounce counters.
module rv_periph_ctrl
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR  = ADDRESS_PER,
    parameter int              N_HEX      = 4,
    parameter int              N_KEY      = 4,
    parameter int              DEB_CYCLES = 50000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [XLEN-1:0]    addr_i,
    input  logic [3:0]         be_i,
    input  logic [XLEN-1:0]    wdata_i,
    output logic               sel_o,
    output logic               rvalid_o,
    output logic [XLEN-1:0]    rdata_o,
    input  logic [N_KEY-1:0]   key_i,
    output logic [7*N_HEX-1:0] hex_o,
    output logic               irq_o
);

    if (N_HEX < 1 || N_HEX > 8) begin : g_chk_hex
        $error("rv_periph_ctrl: N_HEX must be 1..8");
    end
    if (N_KEY < 1 || N_KEY > 16) begin : g_chk_key
        $error("rv_periph_ctrl: N_KEY must be 1..16");
    end
    if (DEB_CYCLES < 2) begin : g_chk_deb
        $error("rv_periph_ctrl: DEB_CYCLES must be >= 2");
    end

    localparam logic [XLEN-1:0] CTRL_MASK =
        (XLEN'(1) << PER_CTRL_IRQ_BIT) | XLEN'((64'd1 << N_HEX) - 64'd1);
    localparam logic [XLEN-1:0] HEX_MASK = XLEN'((64'd1 << (4*N_HEX)) - 64'd1);

    logic [XLEN-1:0]    off;
    logic [3:0]         reg_off;
    logic [XLEN-1:0]    wmask;
    logic               acc;
    logic               wr;
    logic [XLEN-1:0]    rd_val;
    logic [XLEN-1:0]    ctrl_q;
    logic [XLEN-1:0]    hex_q;
    logic [N_KEY-1:0]   edge_q;
    logic [N_KEY-1:0]   edge_clr;
    logic [N_KEY-1:0]   key_sync1;
    logic [N_KEY-1:0]   key_sync2;
    logic [N_KEY-1:0]   key_stable;
    logic [N_KEY-1:0]   stable_nxt;
    logic [N_KEY-1:0]   press;
    logic [7*N_HEX-1:0] seg_nxt;

    // Unsigned offset compare handles any BASE_ADDR alignment.
    assign off     = addr_i - BASE_ADDR;
    assign sel_o   = (off < XLEN'(16));
    assign reg_off = {off[3:2], 2'b00};
    assign wmask   = be_to_mask(be_i);
    assign acc     = req_i & sel_o;
    assign wr      = acc & we_i;

    always_comb begin
        rd_val = '0;
        case (reg_off)
            PER_CTRL_OFF: rd_val = ctrl_q;
            PER_HEX_OFF:  rd_val = hex_q;
            PER_KEY_OFF:  rd_val = XLEN'(key_stable);
            PER_EDGE_OFF: rd_val = XLEN'(edge_q);
            default:      rd_val = '0;
        endcase
    end

    assign edge_clr = (wr && reg_off == PER_EDGE_OFF) ? (wdata_i[N_KEY-1:0] & wmask[N_KEY-1:0])
                                                      : '0;
    assign press    = stable_nxt & ~key_stable;

    // ---- key synchroniser and stable level ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_sync1  <= '0;
            key_sync2  <= '0;
            key_stable <= '0;
        end else begin
            key_sync1  <= key_i;
            key_sync2  <= key_sync1;
            key_stable <= stable_nxt;
        end
    end

`ifdef RV_PERIPH_DEBOUNCE_EN
    localparam int             CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] deb_cnt [N_KEY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_KEY; k++) deb_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_KEY; k++) begin
                if (key_sync2[k] == key_stable[k] || deb_cnt[k] == CNT_LAST)
                    deb_cnt[k] <= '0;
                else
                    deb_cnt[k] <= deb_cnt[k] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        stable_nxt = key_stable;
        for (int k = 0; k < N_KEY; k++) begin
            if (key_sync2[k] != key_stable[k] && deb_cnt[k] == CNT_LAST)
                stable_nxt[k] = key_sync2[k];
        end
    end
`else
    assign stable_nxt = key_sync2;
`endif

    for (genvar d = 0; d < N_HEX; d++) begin : g_digit
        seg7_t seg_dec;
        rv_hex7seg u_dec (
            .nibble_i (hex_q[4*d +: 4]),
            .seg_o    (seg_dec)
        );
        assign seg_nxt[7*d +: 7] = ctrl_q[d] ? seg_dec : SEG7_BLANK;
    end

    // ---- register file, response and display stage ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            hex_q    <= '0;
            edge_q   <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            hex_o    <= '1;
        end else begin
            rvalid_o <= acc;
            rdata_o  <= (acc && !we_i) ? rd_val : '0;
            if (wr && reg_off == PER_CTRL_OFF)
                ctrl_q <= ((ctrl_q & ~wmask) | (wdata_i & wmask)) & CTRL_MASK;
            if (wr && reg_off == PER_HEX_OFF)
                hex_q <= ((hex_q & ~wmask) | (wdata_i & wmask)) & HEX_MASK;
            // A new press in the same cycle as its clear keeps the flag set.
            edge_q   <= (edge_q & ~edge_clr) | press;
            hex_o    <= seg_nxt;
        end
    end

    assign irq_o = ctrl_q[PER_CTRL_IRQ_BIT] & (|edge_q);

endmodule

// File: doc/rv_periph_ctrl.md
RV_PERIPH_CTRL -- requirements
Module: rv_periph_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default rv_pkg::ADDRESS_PER (32'h8000_0000), base of the 16-byte register window.
REQ-002 Parameter N_HEX, default 4, seven-segment digit count, legal 1..8.
REQ-003 Parameter N_KEY, default 4, key input count, legal 1..16.
REQ-004 Parameter DEB_CYCLES, default 50000, debounce stability count, legal >=2.
REQ-005 clk_i  input  1  clock; all logic on the rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 req_i  input  1  access request.
REQ-008 we_i  input  1  write (1) / read (0).
REQ-009 addr_i  input  XLEN  byte address.
REQ-010 be_i  input  4  write byte enables.
REQ-011 wdata_i  input  XLEN  write data.
REQ-012 sel_o  output  1  combinational; 1 when addr_i is in [BASE_ADDR, BASE_ADDR+0xF].
REQ-013 rvalid_o  output  1  one-cycle response strobe.
REQ-014 rdata_o  output  XLEN  read data, valid with rvalid_o.
REQ-015 key_i  input  N_KEY  raw asynchronous keys, 1 = pressed.
REQ-016 hex_o  output  7*N_HEX  registered segments, active-low; digit d on bits [7d+6:7d].
REQ-017 irq_o  output  1  key-press interrupt, level.

Function
REQ-018 Register map (offset, addr_i[1:0] ignored): 0x0 CTRL (RW: [N_HEX-1:0] digit enable, bit 16 irq enable); 0x4 HEX (RW: nibble d at [4d+3:4d]); 0x8 KEY (RO, debounced levels); 0xC KEY_EDGE (sticky press flags, write-1-to-clear).
REQ-019 An access SHALL be accepted in any cycle with req_i=1 and sel_o=1; no backpressure, back-to-back accepts allowed.
REQ-020 rvalid_o SHALL pulse exactly one cycle after each accepted access; rdata_o SHALL then hold register contents as of the accept cycle for reads and 0 for writes.
REQ-021 Writes SHALL update only bytes with be_i set; unimplemented bits read 0 and ignore writes; writes to KEY are ignored.
REQ-022 Each key SHALL pass a 2-flop synchroniser; debounce counter (width $clog2(DEB_CYCLES+1)) increments while synced != stable, clears when equal, and on reaching DEB_CYCLES-1 updates stable and clears.
REQ-023 A stable 0->1 transition SHALL set the KEY_EDGE bit; if set and W1C coincide on a bit, set wins.
REQ-024 irq_o SHALL equal CTRL[16] AND OR(KEY_EDGE), driven from registers.
REQ-025 hex_o digit d SHALL, one cycle after HEX/CTRL change, show the decoded nibble (0-F) if CTRL[d]=1, else 7'h7F.

Reset
REQ-026 rst_i SHALL clear CTRL, HEX, KEY_EDGE, synchronisers, stable levels, counters, rvalid_o, rdata_o, and set hex_o to all ones.
REQ-027 An access accepted in the cycle reset asserts SHALL produce no response.

Configuration
REQ-028 With RV_PERIPH_DEBOUNCE_EN defined, REQ-022 debounce SHALL be present; undefined, stable SHALL equal the synchroniser output (press-to-KEY latency 3 cycles), no counters, DEB_CYCLES ignored.

Structure
REQ-029 rv_pkg SHALL gain register offset constants (PER_CTRL_OFF, PER_HEX_OFF, PER_KEY_OFF, PER_EDGE_OFF) and a seven-segment typedef; existing ADDRESS_HEX/ADDRESS_KEY remain consistent with BASE_ADDR+0x4/+0x8.
REQ-030 Nibble-to-segment decoding SHALL be a combinational sub-module rv_hex7seg, instantiated N_HEX times.

Verification (DEB_CYCLES=4, debounce enabled)
REQ-031 Write 0x8000_0004 data 0x0000_1234 be 4'hF, CTRL=0x0F -> next-cycle hex_o digits 0..3 = 7'h19,7'h30,7'h24,7'h79.
REQ-032 key_i[1] high for 3 cycles then low -> KEY stays 0, KEY_EDGE stays 0, irq_o 0.
REQ-033 key_i[1] held high, CTRL=0x0001_0000 -> KEY=0x2 after 2+4 cycles, KEY_EDGE=0x2, irq_o=1; write 0x2 to 0xC -> KEY_EDGE=0, irq_o=0.
REQ-034 Write HEX be 4'h1 data 0xFFFF_FFFF after 0x1234 -> read HEX = 0x0000_12FF, rvalid_o exactly one cycle after accept.
REQ-035 Read at 0x8000_0010 -> sel_o=0, no rvalid_o; rst_i pulsed mid-read -> no rvalid_o, all registers 0.
